// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants, sync polarity encodings and the colour-bar table
// shared by the VGA timing generator files.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam logic POL_NEG = 1'b0;
    localparam logic POL_POS = 1'b1;

    localparam int BAR_COUNT = 8;

    // Raw per-pixel control flags, all active-high before polarity is applied
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic fs;
    } vga_ctl_t;

    // Colour-bar table: {red, green, blue} on/off per bar, white down to black
    function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
        case (bar)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enable gated shift register that carries raster control flags alongside the
// renderer latency; cleared to all-zero (inactive) by the async active-low reset.
module vga_delay_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift one stage per enabled pixel clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= {WIDTH{1'b0}};
            end
        end else if (i_ce) begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with pixel request/return path; sync and blank are delayed to
// line up with returned colour. Optional colour-bar source enabled by VGA_TEST_PATTERN_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic H_POL    = POL_NEG,
    parameter logic V_POL    = POL_NEG,
    parameter int   COLOR_W  = 8,
    parameter int   PIX_LAT  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ce,
    input  logic                        pat_en,
    output logic                        pix_req,
    output logic [$clog2(H_ACTIVE)-1:0] pix_x,
    output logic [$clog2(V_ACTIVE)-1:0] pix_y,
    input  logic [COLOR_W-1:0]          in_red,
    input  logic [COLOR_W-1:0]          in_green,
    input  logic [COLOR_W-1:0]          in_blue,
    output logic [COLOR_W-1:0]          red,
    output logic [COLOR_W-1:0]          green,
    output logic [COLOR_W-1:0]          blue,
    output logic                        h_sync,
    output logic                        v_sync,
    output logic                        blank_n,
    output logic                        sync_n,
    output logic                        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int PX_W    = $clog2(H_ACTIVE);
    localparam int PY_W    = $clog2(V_ACTIVE);

    // Boundaries are one bit wider than the counters so an end point equal to 2**W cannot wrap
    localparam logic [HC_W:0]   H_ACT_END = (HC_W+1)'(H_ACTIVE);
    localparam logic [HC_W:0]   HS_BEG    = (HC_W+1)'(H_ACTIVE + H_FP);
    localparam logic [HC_W:0]   HS_END    = (HC_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W:0]   V_ACT_END = (VC_W+1)'(V_ACTIVE);
    localparam logic [VC_W:0]   VS_BEG    = (VC_W+1)'(V_ACTIVE + V_FP);
    localparam logic [VC_W:0]   VS_END    = (VC_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HC_W-1:0] HC_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] VC_LAST   = VC_W'(V_TOTAL - 1);

    logic [HC_W-1:0] r_hc;
    logic [VC_W-1:0] r_vc;
    logic [HC_W:0]   w_hc_ext;
    logic [VC_W:0]   w_vc_ext;
    logic            w_pix_req;
    vga_ctl_t        w_ctl;
    vga_ctl_t        w_ctl_d;
    logic [COLOR_W-1:0] w_red;
    logic [COLOR_W-1:0] w_green;
    logic [COLOR_W-1:0] w_blue;

    // Raster position counters; the line counter advances on the last pixel of each line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hc <= {HC_W{1'b0}};
            r_vc <= {VC_W{1'b0}};
        end else if (ce) begin
            if (r_hc == HC_LAST) begin
                r_hc <= {HC_W{1'b0}};
                if (r_vc == VC_LAST) begin
                    r_vc <= {VC_W{1'b0}};
                end else begin
                    r_vc <= r_vc + {{(VC_W-1){1'b0}}, 1'b1};
                end
            end else begin
                r_hc <= r_hc + {{(HC_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Stage-0 decode of visibility, sync windows and frame origin from the counters
    always_comb begin
        w_hc_ext  = {1'b0, r_hc};
        w_vc_ext  = {1'b0, r_vc};
        w_pix_req = (w_hc_ext < H_ACT_END) && (w_vc_ext < V_ACT_END);
        w_ctl.act = w_pix_req;
        w_ctl.hs  = (w_hc_ext >= HS_BEG) && (w_hc_ext < HS_END);
        w_ctl.vs  = (w_vc_ext >= VS_BEG) && (w_vc_ext < VS_END);
        w_ctl.fs  = (r_hc == {HC_W{1'b0}}) && (r_vc == {VC_W{1'b0}});
    end

    assign pix_req = w_pix_req;
    assign pix_x   = w_pix_req ? r_hc[PX_W-1:0] : {PX_W{1'b0}};
    assign pix_y   = w_pix_req ? r_vc[PY_W-1:0] : {PY_W{1'b0}};
    assign sync_n  = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
    localparam int DL_W = $bits(vga_ctl_t) + 3;
    logic [2:0]      w_bar;
    logic [2:0]      w_bar_d;
    logic [2:0]      w_bar_rgb;
    logic [DL_W-1:0] w_dl_in;
    logic [DL_W-1:0] w_dl_out;

    // Bar index travels down the delay line with the control flags of the same pixel
    always_comb begin
        w_bar = 3'((int'(pix_x) * BAR_COUNT) / H_ACTIVE);
    end

    assign w_dl_in            = {w_bar, w_ctl};
    assign {w_bar_d, w_ctl_d} = w_dl_out;
`else
    localparam int DL_W = $bits(vga_ctl_t);
    logic [DL_W-1:0] w_dl_in;
    logic [DL_W-1:0] w_dl_out;

    assign w_dl_in = w_ctl;
    assign w_ctl_d = w_dl_out;
`endif

    vga_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (PIX_LAT)
    ) u_ctl_delay (
        .clk   (clk),
        .rst_n (reset),
        .i_ce  (ce),
        .i_d   (w_dl_in),
        .o_q   (w_dl_out)
    );

    // Colour source select; anything outside the visible window is driven black
    always_comb begin
        w_red   = {COLOR_W{1'b0}};
        w_green = {COLOR_W{1'b0}};
        w_blue  = {COLOR_W{1'b0}};
`ifdef VGA_TEST_PATTERN_EN
        w_bar_rgb = bar_rgb(w_bar_d);
`endif
        if (w_ctl_d.act) begin
`ifdef VGA_TEST_PATTERN_EN
            if (pat_en) begin
                w_red   = {COLOR_W{w_bar_rgb[2]}};
                w_green = {COLOR_W{w_bar_rgb[1]}};
                w_blue  = {COLOR_W{w_bar_rgb[0]}};
            end else begin
                w_red   = in_red;
                w_green = in_green;
                w_blue  = in_blue;
            end
`else
            w_red   = in_red;
            w_green = in_green;
            w_blue  = in_blue;
`endif
        end else begin
            w_red   = {COLOR_W{1'b0}};
            w_green = {COLOR_W{1'b0}};
            w_blue  = {COLOR_W{1'b0}};
        end
    end

    // DAC-facing output register; sync polarity applied here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            red         <= {COLOR_W{1'b0}};
            green       <= {COLOR_W{1'b0}};
            blue        <= {COLOR_W{1'b0}};
            blank_n     <= 1'b0;
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            frame_start <= 1'b0;
        end else if (ce) begin
            red         <= w_red;
            green       <= w_green;
            blue        <= w_blue;
            blank_n     <= w_ctl_d.act;
            h_sync      <= w_ctl_d.hs ? H_POL : ~H_POL;
            v_sync      <= w_ctl_d.vs ? V_POL : ~V_POL;
            frame_start <= w_ctl_d.fs;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance for line timing and a tiny-raster instance
// (16x8 totals, PIX_LAT=2, positive h_sync) so whole frames fit in a short run.
module tb_vga_timing_gen;

    logic       clk;
    logic       reset;
    logic       ce;
    logic       pat_en;
    logic [7:0] in_red;
    logic [7:0] in_green;
    logic [7:0] in_blue;

    logic       d_pix_req;
    logic [9:0] d_pix_x;
    logic [8:0] d_pix_y;
    logic [7:0] d_red, d_green, d_blue;
    logic       d_h_sync, d_v_sync, d_blank_n, d_sync_n, d_frame_start;

    logic       s_pix_req;
    logic [2:0] s_pix_x;
    logic [1:0] s_pix_y;
    logic [7:0] s_red, s_green, s_blue;
    logic       s_h_sync, s_v_sync, s_blank_n, s_sync_n, s_frame_start;

    int n_checks;
    int n_errors;
    int t;
    int d_hs_lo;
    int d_fs_cnt;
    int s_vs_lo;
    int s_fs_t[$];
    int rises[$];
    int hold_viol;
    logic found;
    logic prev_blank;
    logic [81:0] snap;

    vga_timing_gen u_dut (
        .clk(clk), .reset(reset), .ce(ce), .pat_en(pat_en),
        .pix_req(d_pix_req), .pix_x(d_pix_x), .pix_y(d_pix_y),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .red(d_red), .green(d_green), .blue(d_blue),
        .h_sync(d_h_sync), .v_sync(d_v_sync), .blank_n(d_blank_n),
        .sync_n(d_sync_n), .frame_start(d_frame_start)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0), .COLOR_W(8), .PIX_LAT(2)
    ) u_small (
        .clk(clk), .reset(reset), .ce(ce), .pat_en(pat_en),
        .pix_req(s_pix_req), .pix_x(s_pix_x), .pix_y(s_pix_y),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .red(s_red), .green(s_green), .blue(s_blue),
        .h_sync(s_h_sync), .v_sync(s_v_sync), .blank_n(s_blank_n),
        .sync_n(s_sync_n), .frame_start(s_frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [81:0] outs();
        return {d_red, d_green, d_blue, d_h_sync, d_v_sync, d_blank_n, d_frame_start,
                d_pix_req, d_pix_x, d_pix_y,
                s_red, s_green, s_blue, s_h_sync, s_v_sync, s_blank_n, s_frame_start,
                s_pix_req, s_pix_x, s_pix_y};
    endfunction

    // Advance to clock count 'target' after reset release, tallying sync/frame events
    task automatic run_to(input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
            if (d_h_sync === 1'b0) d_hs_lo++;
            if (d_frame_start === 1'b1) d_fs_cnt++;
            if (s_v_sync === 1'b0) s_vs_lo++;
            if (s_frame_start === 1'b1) s_fs_t.push_back(t);
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; t = 0;
        d_hs_lo = 0; d_fs_cnt = 0; s_vs_lo = 0; hold_viol = 0;
        reset = 1'b0; ce = 1'b1; pat_en = 1'b0;
        in_red = 8'hAA; in_green = 8'hAA; in_blue = 8'hAA;
        repeat (2) @(negedge clk);

        chk("rst_red", 32'(d_red), 32'h0);
        chk("rst_blank_n", 32'(d_blank_n), 32'h0);
        chk("rst_h_sync", 32'(d_h_sync), 32'h1);
        chk("rst_v_sync", 32'(d_v_sync), 32'h1);
        chk("rst_frame_start", 32'(d_frame_start), 32'h0);
        chk("sync_n", 32'(d_sync_n), 32'h0);
        chk("rst_pix_req", 32'(d_pix_req), 32'h1);
        chk("rst_pix_x", 32'(d_pix_x), 32'h0);
        chk("s_rst_h_sync_pos", 32'(s_h_sync), 32'h0);
        chk("s_rst_v_sync", 32'(s_v_sync), 32'h1);

        reset = 1'b1;
        run_to(1);
        chk("t1_frame_start", 32'(d_frame_start), 32'h0);
        chk("t1_blank_n", 32'(d_blank_n), 32'h0);
        chk("t1_pix_x", 32'(d_pix_x), 32'd1);
        run_to(2);
        chk("t2_frame_start", 32'(d_frame_start), 32'h1);
        chk("t2_blank_n", 32'(d_blank_n), 32'h1);
        chk("t2_red", 32'(d_red), 32'hAA);
        chk("t2_blue", 32'(d_blue), 32'hAA);
        chk("s_t2_blank_n", 32'(s_blank_n), 32'h0);
        run_to(3);
        chk("t3_fs_pulse", 32'(d_frame_start), 32'h0);
        chk("s_t3_frame_start", 32'(s_frame_start), 32'h1);
        chk("s_t3_green", 32'(s_green), 32'hAA);

        run_to(12);  chk("s_hs_before", 32'(s_h_sync), 32'h0);
        run_to(13);  chk("s_hs_first", 32'(s_h_sync), 32'h1);
        run_to(15);  chk("s_hs_last", 32'(s_h_sync), 32'h1);
        run_to(16);  chk("s_hs_after", 32'(s_h_sync), 32'h0);
        run_to(58);  chk("s_blank_last_vis", 32'(s_blank_n), 32'h1);
                     chk("s_red_last_vis", 32'(s_red), 32'hAA);
        run_to(59);  chk("s_blank_fp", 32'(s_blank_n), 32'h0);
                     chk("s_red_fp", 32'(s_red), 32'h0);
        run_to(82);  chk("s_vs_before", 32'(s_v_sync), 32'h1);
        run_to(83);  chk("s_vs_first", 32'(s_v_sync), 32'h0);
        run_to(114); chk("s_vs_last", 32'(s_v_sync), 32'h0);
        run_to(115); chk("s_vs_after", 32'(s_v_sync), 32'h1);
        run_to(131); chk("s_fs_frame2", 32'(s_frame_start), 32'h1);

        run_to(641); chk("blank_x639", 32'(d_blank_n), 32'h1);
                     chk("red_x639", 32'(d_red), 32'hAA);
        run_to(642); chk("blank_x640", 32'(d_blank_n), 32'h0);
                     chk("red_x640", 32'(d_red), 32'h0);
                     chk("green_x640", 32'(d_green), 32'h0);
        run_to(657); chk("hs_before", 32'(d_h_sync), 32'h1);
        run_to(658); chk("hs_first", 32'(d_h_sync), 32'h0);
        run_to(753); chk("hs_last", 32'(d_h_sync), 32'h0);
        run_to(754); chk("hs_after", 32'(d_h_sync), 32'h1);
        run_to(799); chk("pix_req_hc799", 32'(d_pix_req), 32'h0);
                     chk("pix_x_blank", 32'(d_pix_x), 32'h0);
        run_to(800); chk("pix_req_line1", 32'(d_pix_req), 32'h1);
                     chk("pix_x_line1", 32'(d_pix_x), 32'h0);
                     chk("pix_y_line1", 32'(d_pix_y), 32'h1);
        run_to(801); chk("blank_hc799", 32'(d_blank_n), 32'h0);
        run_to(802); chk("blank_line1", 32'(d_blank_n), 32'h1);

        chk("hs_low_count", 32'(d_hs_lo), 32'd96);
        chk("fs_count", 32'(d_fs_cnt), 32'd1);
        chk("s_vs_low_count", 32'(s_vs_lo), 32'd192);
        chk("s_fs_count", 32'(s_fs_t.size()), 32'd7);
        if (s_fs_t.size() >= 2) chk("s_frame_period", 32'(s_fs_t[1] - s_fs_t[0]), 32'd128);

        // Alternate ce: nothing may move on a disabled edge, and a line stretches to 1600 clocks
        for (int k = 0; k < 3400; k++) begin
            ce = (k % 2 == 0) ? 1'b1 : 1'b0;
            snap = outs();
            prev_blank = d_blank_n;
            @(negedge clk);
            if (!ce && (outs() !== snap)) hold_viol++;
            if (d_blank_n && !prev_blank) rises.push_back(k);
        end
        ce = 1'b1;
        chk("ce_hold", 32'(hold_viol), 32'd0);
        chk("ce_rise_count", 32'(rises.size() >= 2), 32'h1);
        if (rises.size() >= 2) chk("ce_line_period", 32'(rises[1] - rises[0]), 32'd1600);

        // Reset in the middle of a visible line
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            if (d_pix_req && d_pix_x == 10'd300) found = 1'b1;
        end
        chk("find_hc300", 32'(found), 32'h1);
        chk("pre_rst_blank", 32'(d_blank_n), 32'h1);
        chk("pre_rst_red", 32'(d_red), 32'hAA);
        reset = 1'b0;
        #1;
        chk("mid_rst_red", 32'(d_red), 32'h0);
        chk("mid_rst_blank", 32'(d_blank_n), 32'h0);
        chk("mid_rst_h_sync", 32'(d_h_sync), 32'h1);
        chk("mid_rst_pix_x", 32'(d_pix_x), 32'h0);
        chk("s_mid_rst_h_sync", 32'(s_h_sync), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        t = 0;
`ifdef VGA_TEST_PATTERN_EN
        pat_en = 1'b1;
        in_red = 8'h55; in_green = 8'h55; in_blue = 8'h55;
`endif
        run_to(1);   chk("restart_t1_fs", 32'(d_frame_start), 32'h0);
        run_to(2);   chk("restart_fs", 32'(d_frame_start), 32'h1);
                     chk("restart_blank", 32'(d_blank_n), 32'h1);
        run_to(3);   chk("s_restart_fs", 32'(s_frame_start), 32'h1);
`ifdef VGA_TEST_PATTERN_EN
        run_to(4);   chk("pat_x2_red", 32'(d_red), 32'hFF);
                     chk("pat_x2_blue", 32'(d_blue), 32'hFF);
        run_to(81);  chk("pat_x79_blue", 32'(d_blue), 32'hFF);
        run_to(82);  chk("pat_x80_blue", 32'(d_blue), 32'h00);
                     chk("pat_x80_green", 32'(d_green), 32'hFF);
        run_to(561); chk("pat_x559_red", 32'(d_red), 32'h00);
                     chk("pat_x559_blue", 32'(d_blue), 32'hFF);
        run_to(562); chk("pat_x560_blue", 32'(d_blue), 32'h00);
                     chk("pat_x560_green", 32'(d_green), 32'h00);
        run_to(641); chk("pat_x639_red", 32'(d_red), 32'h00);
        pat_en = 1'b0;
`else
        in_red = 8'h12; in_green = 8'h34; in_blue = 8'h56;
        run_to(4);   chk("rgb_red", 32'(d_red), 32'h12);
                     chk("rgb_green", 32'(d_green), 32'h34);
                     chk("rgb_blue", 32'(d_blue), 32'h56);
        run_to(642); chk("rgb_blank_red", 32'(d_red), 32'h00);
                     chk("rgb_blank_blue", 32'(d_blue), 32'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
